tmp_adc_spi_reader: RTL and testbench

//   SPI master that periodically reads one channel of an external 10-bit SAR ADC (MCP3008-style framing).

---
 rtl/tmp_adc_spi_reader_pkg.sv | 33 +++
 rtl/tmp_adc_spi_reader_if.sv | 14 +
 rtl/tmp_adc_spi_reader_spi_clk_div.sv | 47 ++++
 rtl/tmp_adc_spi_reader.sv | 203 ++++++++++++++++++++
 tb/tb_tmp_adc_spi_reader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/tmp_adc_spi_reader_pkg.sv
// Shared types, constants and helpers for the tmp_adc SPI reader.
//   state_t    : reader FSM states
//   FRAME_BITS : SCLK periods per SPI frame
//   CODE_BITS  : conversion result width (bits after the null bit)
//   AVG_DEPTH  : codes per averaged result (TMP_ADC_AVERAGE_EN builds)
//   build_cmd  : 16-bit command word for a single-ended channel read
//   avg_code   : mean of AVG_DEPTH accumulated codes
package tmp_adc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      DONE
   } state_t;

   localparam int FRAME_BITS   = 16;
   localparam int NULL_BIT_IDX = 6;
   localparam int CODE_BITS    = FRAME_BITS - NULL_BIT_IDX;
   localparam int AVG_DEPTH    = 4;
   localparam int SUM_BITS     = CODE_BITS + $clog2(AVG_DEPTH);

   // start bit, single-ended select, channel, then don't-care clocks
   function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [2:0] ch);
      return {1'b1, 1'b1, ch, 11'b0};
   endfunction

   function automatic logic [CODE_BITS-1:0] avg_code(input logic [SUM_BITS-1:0] sum);
      return sum[SUM_BITS-1 -: CODE_BITS];
   endfunction

endpackage

// File: rtl/tmp_adc_spi_reader_if.sv
// SPI bus between the reader (master) and the external ADC (slave).
//   sclk : SPI clock, mode 0
//   cs_n : chip select, active low
//   mosi : command to the ADC
//   miso : data from the ADC
interface tmp_adc_spi_reader_if;
   logic sclk;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sclk, cs_n, mosi, input miso);
   modport slave  (input sclk, cs_n, mosi, output miso);
endinterface

// File: rtl/tmp_adc_spi_reader_spi_clk_div.sv
// SCLK half-period timer. Counts CLK_DIV clk cycles per half period while en
// is high and strobes rise/fall at the end of the low/high half respectively.
// Held at the start of a low half whenever en is low.
//   clk, rst_n : system clock, async active-low reset
//   en         : run the divider
//   rise, fall : one-cycle strobes, the SCLK edge takes effect on this clk edge
module spi_clk_div #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          high_q, high_d;
   logic          tick;

   always_comb begin
      tick   = en && (cnt_q == '0);
      cnt_d  = RELOAD;
      high_d = 1'b0;
      if (en) begin
         cnt_d  = tick ? RELOAD : cnt_q - 1'b1;
         high_d = tick ? ~high_q : high_q;
      end
   end

   assign rise = tick & ~high_q;
   assign fall = tick & high_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= RELOAD;
         high_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         high_q <= high_d;
      end
   end

endmodule

// File: rtl/tmp_adc_spi_reader.sv
// Periodic SPI reader for a 10-bit MCP3008-style SAR ADC. Each frame returns
// one single-ended conversion on val_out, zero-extended to 16 bits, with a
// one-cycle val_valid strobe.
//   clk, rst_n : system clock, async active-low reset
//   enable     : run the sample timer (an in-flight frame always completes)
//   start      : manual conversion request, accepted only in IDLE
//   spi        : SPI master port (sclk, cs_n, mosi out; miso in)
//   val_out    : last result {6'b0, code}
//   val_valid  : val_out updated this cycle
//   busy       : a frame is in progress
// Build option TMP_ADC_AVERAGE_EN: report the mean of every AVG_DEPTH codes
// instead of every code.
//
// state    | meaning
// IDLE     | cs_n high, waiting for a trigger
// CS_SETUP | cs_n low, first command bit on mosi, CLK_DIV cycles
// SHIFT    | 16 SCLK periods: miso in on rise, next mosi bit on fall
// CS_HOLD  | sclk low, cs_n still low, CLK_DIV cycles
// DONE     | cs_n high, result presented for one cycle
module tmp_adc_spi_reader
   import tmp_adc_pkg::*;
#(
   parameter int         CLK_DIV       = 50,
   parameter int         SAMPLE_PERIOD = 100000,
   parameter logic [2:0] CHANNEL       = 3'd0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        start,
   tmp_adc_spi_reader_if.master        spi,
   output logic [15:0]                 val_out,
   output logic                        val_valid,
   output logic                        busy
);

   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int TW = $clog2(SAMPLE_PERIOD + 1);
   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [PW-1:0]         PH_RELOAD  = PW'(CLK_DIV - 1);
   localparam logic [TW-1:0]         TMR_RELOAD = TW'(SAMPLE_PERIOD - 1);
   localparam logic [BW-1:0]         LAST_BIT   = BW'(FRAME_BITS - 1);
   localparam logic [FRAME_BITS-1:0] CMD        = build_cmd(CHANNEL);

   state_t                state_q, state_d;
   logic [PW-1:0]         ph_cnt_q, ph_cnt_d;
   logic [TW-1:0]         tmr_q, tmr_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [FRAME_BITS-1:0] tx_q, tx_d;
   // Only the last CODE_BITS samples of the frame are kept, so the
   // leading don't-care periods and the null bit fall off the top.
   logic [CODE_BITS-1:0]  rx_q, rx_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_n_q, cs_n_d;
   logic [15:0]           val_q, val_d;
   logic                  valid_q, valid_d;
   logic                  trigger;
   logic                  sclk_rise, sclk_fall;

`ifdef TMP_ADC_AVERAGE_EN
   localparam logic [$clog2(AVG_DEPTH)-1:0] AVG_LAST = $clog2(AVG_DEPTH)'(AVG_DEPTH - 1);
   logic [SUM_BITS-1:0]          acc_q, acc_d, acc_sum;
   logic [$clog2(AVG_DEPTH)-1:0] avg_cnt_q, avg_cnt_d;
`endif

   spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q == SHIFT),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // Down-counting sample timer; reaching zero is the terminal count and
   // reloads regardless of whether the FSM can take the trigger.
   always_comb begin
      trigger = start | (enable & (tmr_q == '0));
      tmr_d   = (!enable || tmr_q == '0) ? TMR_RELOAD : tmr_q - 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      ph_cnt_d  = ph_cnt_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      val_d     = val_q;
      valid_d   = 1'b0;
`ifdef TMP_ADC_AVERAGE_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      acc_sum   = acc_q + SUM_BITS'(rx_q);
`endif
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d  = CS_SETUP;
               cs_n_d   = 1'b0;
               tx_d     = CMD;
               ph_cnt_d = PH_RELOAD;
            end
         end
         CS_SETUP: begin
            if (ph_cnt_q == '0) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         SHIFT: begin
            if (sclk_rise) begin
               sclk_d = 1'b1;
               rx_d   = {rx_q[CODE_BITS-2:0], spi.miso};
            end
            if (sclk_fall) begin
               sclk_d    = 1'b0;
               tx_d      = {tx_q[FRAME_BITS-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d  = CS_HOLD;
                  ph_cnt_d = PH_RELOAD;
               end
            end
         end
         CS_HOLD: begin
            if (ph_cnt_q == '0) begin
               state_d = DONE;
               cs_n_d  = 1'b1;
`ifdef TMP_ADC_AVERAGE_EN
               avg_cnt_d = avg_cnt_q + 1'b1;
               if (avg_cnt_q == AVG_LAST) begin
                  val_d   = 16'(avg_code(acc_sum));
                  valid_d = 1'b1;
                  acc_d   = '0;
               end else begin
                  acc_d = acc_sum;
               end
`else
               val_d   = 16'(rx_q);
               valid_d = 1'b1;
`endif
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ph_cnt_q  <= '0;
         tmr_q     <= TMR_RELOAD;
         bit_cnt_q <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         val_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_cnt_q  <= ph_cnt_d;
         tmr_q     <= tmr_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         val_q     <= val_d;
         valid_q   <= valid_d;
      end
   end

`ifdef TMP_ADC_AVERAGE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q     <= '0;
         avg_cnt_q <= '0;
      end else begin
         acc_q     <= acc_d;
         avg_cnt_q <= avg_cnt_d;
      end
   end
`endif

   assign spi.sclk  = sclk_q;
   assign spi.cs_n  = cs_n_q;
   assign spi.mosi  = tx_q[FRAME_BITS-1];
   assign val_out   = val_q;
   assign val_valid = valid_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_tmp_adc_spi_reader.sv
// Directed bench for tmp_adc_spi_reader with CLK_DIV=2, SAMPLE_PERIOD=200 and
// a behavioural ADC that presents code bits after each SCLK falling edge.
module tb_tmp_adc_spi_reader;

   localparam int CLK_DIV       = 2;
   localparam int SAMPLE_PERIOD = 200;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b0;
   logic        start  = 1'b0;
   logic [15:0] val_out;
   logic        val_valid;
   logic        busy;

   tmp_adc_spi_reader_if spi();

   tmp_adc_spi_reader #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .CHANNEL       (3'd0)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .start     (start),
      .spi       (spi),
      .val_out   (val_out),
      .val_valid (val_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // ADC model: falls = SCLK falling edges seen in this frame; period k
   // (1-based) drives its bit once k-1 falls have happened.
   int          falls    = 0;
   logic [9:0]  adc_code = '0;
   logic [15:0] mosi_sh  = '0;
   logic        miso_bit;

   always @(negedge spi.sclk or posedge spi.cs_n) begin
      if (spi.cs_n) falls = 0;
      else          falls = falls + 1;
   end

   always_comb begin
      miso_bit = 1'b0;
      if (falls >= 6 && falls <= 15) miso_bit = adc_code[15 - falls];
   end
   assign spi.miso = miso_bit;

   always @(posedge spi.sclk) mosi_sh = {mosi_sh[14:0], spi.mosi};

   int          cyc       = 0;
   int          n_valid   = 0;
   int          n_cs_low  = 0;
   int          n_busy    = 0;
   int          valid_cyc = 0;
   logic [15:0] last_val  = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (val_valid) begin
         n_valid   = n_valid + 1;
         valid_cyc = cyc;
         last_val  = val_out;
      end
      if (!spi.cs_n) n_cs_low = n_cs_low + 1;
      if (busy)      n_busy   = n_busy + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stimulus is applied 2 time units after the edge that starts cycle cyc.
   task automatic wait_to(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse_start(output int trig);
      trig  = cyc;
      start = 1'b1;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   initial begin
      int t, t2, e, f, v0, c0, b0;
`ifdef TMP_ADC_AVERAGE_EN
      logic [9:0] avg_codes [4];
`endif
      wait_to(3);
      chk("rst_cs_n", spi.cs_n, 1);
      chk("rst_sclk", spi.sclk, 0);
      chk("rst_mosi", spi.mosi, 0);
      chk("rst_val_out", val_out, 0);
      chk("rst_val_valid", val_valid, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_to(6);

`ifdef TMP_ADC_AVERAGE_EN
      avg_codes = '{10'd100, 10'd101, 10'd102, 10'd105};
      v0 = n_valid;
      for (int i = 0; i < 4; i++) begin
         adc_code = avg_codes[i];
         pulse_start(t);
         wait_to(t + 80);
         chk("avg_nvalid", n_valid - v0, (i == 3) ? 1 : 0);
      end
      chk("avg_val", last_val, 16'd102);
`else
      // single manual frame
      adc_code = 10'h26C;
      v0 = n_valid; c0 = n_cs_low; b0 = n_busy;
      pulse_start(t);
      wait_to(t + 100);
      chk("t1_cs_low", n_cs_low - c0, 68);
      chk("t1_mosi", mosi_sh, 16'hC000);
      chk("t1_val", last_val, 16'h026C);
      chk("t1_nvalid", n_valid - v0, 1);
      chk("t1_latency", valid_cyc - t, 69);
      chk("t1_busy", n_busy - b0, 69);

      // timer-driven frames, then enable dropped mid-frame
      adc_code = 10'h000;
      v0 = n_valid;
      e = cyc;
      enable = 1'b1;
      wait_to(e + 280);
      chk("t2_val0", last_val, 16'h0000);
      chk("t2_cyc0", valid_cyc, e + 268);
      chk("t2_n0", n_valid - v0, 1);
      adc_code = 10'h3FF;
      wait_to(e + 480);
      chk("t2_val1", last_val, 16'h03FF);
      chk("t2_cyc1", valid_cyc, e + 468);
      chk("t2_n1", n_valid - v0, 2);
      adc_code = 10'h155;
      wait_to(e + 620);
      enable = 1'b0;
      wait_to(e + 700);
      chk("t2_val2", last_val, 16'h0155);
      chk("t2_cyc2", valid_cyc, e + 668);
      chk("t2_n2", n_valid - v0, 3);
      v0 = n_valid;
      wait_to(e + 900);
      chk("t2_disabled", n_valid - v0, 0);

      // start coincident with timer terminal count
      adc_code = 10'h0AA;
      v0 = n_valid; c0 = n_cs_low;
      f = cyc;
      enable = 1'b1;
      wait_to(f + 199);
      pulse_start(t);
      wait_to(f + 300);
      enable = 1'b0;
      chk("t5_nvalid", n_valid - v0, 1);
      chk("t5_cs_low", n_cs_low - c0, 68);
      chk("t5_cyc", valid_cyc, f + 268);
      chk("t5_val", last_val, 16'h00AA);

      // start while busy is dropped
      adc_code = 10'h1C3;
      v0 = n_valid; c0 = n_cs_low; b0 = n_busy;
      pulse_start(t);
      wait_to(t + 10);
      pulse_start(t2);
      wait_to(t + 200);
      chk("t3_nvalid", n_valid - v0, 1);
      chk("t3_busy", n_busy - b0, 69);
      chk("t3_cs_low", n_cs_low - c0, 68);
      chk("t3_val", last_val, 16'h01C3);

      // reset in the 20th SHIFT cycle
      adc_code = 10'h3A5;
      v0 = n_valid;
      pulse_start(t);
      wait_to(t + 22);
      chk("t4_pre_sclk", spi.sclk, 1);
      rst_n = 1'b0;
      #1;
      chk("t4_cs_n", spi.cs_n, 1);
      chk("t4_sclk", spi.sclk, 0);
      chk("t4_mosi", spi.mosi, 0);
      chk("t4_busy", busy, 0);
      chk("t4_val_out", val_out, 16'h0000);
      wait_to(t + 26);
      rst_n = 1'b1;
      wait_to(t + 100);
      chk("t4_no_valid", n_valid - v0, 0);
      adc_code = 10'h2A5;
      v0 = n_valid; c0 = n_cs_low;
      pulse_start(t);
      wait_to(t + 100);
      chk("t4_nvalid", n_valid - v0, 1);
      chk("t4_cs_low", n_cs_low - c0, 68);
      chk("t4_mosi_cmd", mosi_sh, 16'hC000);
      chk("t4_val", last_val, 16'h02A5);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
